// File: rtl/booth_pp_pipe.sv
// Two-stage radix-4 Booth partial-product generator feeding the Wallace tree; 2-cycle latency, 1 op/cycle.
// Backpressure: valid/ready with no skid buffer, so in_ready depends combinationally on out_ready.
module booth_pp_pipe #(
   parameter int N     = 16,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_a,
   input  logic [N-1:0]       in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*N-1:0]     out_pp [0:N/2],
   output logic [TAG_W-1:0]   out_tag
);

   localparam int NUM_PP = N/2 + 1;

   typedef struct packed {
      logic [2*N-1:0]   a_ext;
      logic [N+1:0]     b_ext;
      logic [TAG_W-1:0] tag;
   } s1_t;

   logic           s1_valid;
   s1_t            s1_q;
   s1_t            s1_d;
   logic           s2_valid;
   logic           s2_load;
   logic           in_xfer;
   logic [N+2:0]   bx;
   logic [2*N-1:0] pp_nxt [0:NUM_PP-1];

   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign in_ready  = ~s1_valid | s2_load;
   assign in_xfer   = in_valid & in_ready;
   assign out_valid = s2_valid;

   // Signedness is folded into the extension here, so the Booth stage is mode-agnostic.
   assign s1_d.a_ext = {{N{in_signed & in_a[N-1]}}, in_a};
   assign s1_d.b_ext = {{2{in_signed & in_b[N-1]}}, in_b};
   assign s1_d.tag   = in_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_xfer) begin
         s1_valid <= 1'b1;
         s1_q     <= s1_d;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Appending a zero below the LSB supplies b[-1] for digit 0.
   assign bx = {s1_q.b_ext, 1'b0};

   for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
      logic [2:0]     grp;
      logic [2*N-1:0] mag;

      assign grp = bx[2*i+2 -: 3];

      always_comb begin
         mag = '0;
         case (grp)
            3'b001, 3'b010: mag = s1_q.a_ext;
            3'b011:         mag = s1_q.a_ext << 1;
            3'b100:         mag = -(s1_q.a_ext << 1);
            3'b101, 3'b110: mag = -s1_q.a_ext;
            default:        mag = '0;
         endcase
      end

      assign pp_nxt[i] = mag << (2*i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_tag  <= '0;
         for (int i = 0; i < NUM_PP; i++) out_pp[i] <= '0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         out_tag  <= s1_q.tag;
         for (int i = 0; i < NUM_PP; i++) out_pp[i] <= pp_nxt[i];
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule
